// File: rtl/spi_mcp3202_pkg.sv
// Shared types and constants for the MCP3202 SPI responder.
// Command bit positions index o_CFG, which is {SGL, ODD, MSBF}.
package spi_mcp3202_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WAIT_START,
    GET_SGL,
    GET_ODD,
    GET_MSBF,
    NULL_BIT,
    SHIFT_MSB,
    SHIFT_LSB,
    HOLD
  } state_t;

  localparam int CFG_SGL  = 2;
  localparam int CFG_ODD  = 1;
  localparam int CFG_MSBF = 0;

  localparam logic NULL_BIT_VAL = 1'b0;

  // ODD alone picks the channel: CH1 for single-ended CH1 and for CH1-CH0 diff.
  function automatic logic use_ch1(input logic [2:0] cfg);
    return cfg[CFG_ODD];
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for one asynchronous SPI pin, with registered
// rise/fall strobes one clock after the synchronized level changes.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [SYNC_STAGES:0]   warm_q;

  // Edges stay masked until the chain has flushed its reset value, so a pin
  // already sitting opposite to RESET_VAL after reset is not seen as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
      warm_q <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
      warm_q <= {warm_q[SYNC_STAGES-1:0], 1'b1};
      rise   <= warm_q[SYNC_STAGES] &  sync_q[SYNC_STAGES-1] & ~prev_q;
      fall   <= warm_q[SYNC_STAGES] & ~sync_q[SYNC_STAGES-1] &  prev_q;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_mcp3202_responder.sv
// MCP3202-style SPI slave: decodes start/SGL/ODD/MSBF on SCK rises and shifts
// a null bit plus the latched sample out on SCK falls.
module spi_mcp3202_responder
  import spi_mcp3202_pkg::*;
#(
  parameter int DATA_WIDTH  = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_CS,
  input  logic                  i_SCK,
  input  logic                  i_MOSI,
  input  logic [DATA_WIDTH-1:0] i_CH0_DATA,
  input  logic [DATA_WIDTH-1:0] i_CH1_DATA,
  output logic                  o_MISO,
  output logic                  o_MISO_OE,
  output logic [2:0]            o_CFG,
  output logic                  o_CONV_DONE
);

  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  logic cs_level_unused;
  logic cs_rise;
  logic cs_fall;
  logic sck_level_unused;
  logic sck_rise;
  logic sck_fall;
  logic mosi;
  logic mosi_rise_unused;
  logic mosi_fall_unused;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] sample_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  sgl_q;
  logic                  odd_q;

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b1)
  ) u_sync_cs (
    .clk   (clk),
    .rst   (rst),
    .din   (i_CS),
    .level (cs_level_unused),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b0)
  ) u_sync_sck (
    .clk   (clk),
    .rst   (rst),
    .din   (i_SCK),
    .level (sck_level_unused),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b0)
  ) u_sync_mosi (
    .clk   (clk),
    .rst   (rst),
    .din   (i_MOSI),
    .level (mosi),
    .rise  (mosi_rise_unused),
    .fall  (mosi_fall_unused)
  );

  // CS rise overrides everything, including an SCK edge seen on the same clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      o_MISO      <= 1'b0;
      o_MISO_OE   <= 1'b0;
      o_CFG       <= 3'b000;
      o_CONV_DONE <= 1'b0;
      sample_q    <= '0;
      idx_q       <= '0;
      sgl_q       <= 1'b0;
      odd_q       <= 1'b0;
    end else begin
      o_CONV_DONE <= 1'b0;
      if (cs_rise) begin
        state_q   <= IDLE;
        o_MISO    <= 1'b0;
        o_MISO_OE <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            o_MISO    <= 1'b0;
            o_MISO_OE <= 1'b0;
            if (cs_fall) begin
              state_q   <= WAIT_START;
              o_MISO_OE <= 1'b1;
            end
          end
          WAIT_START: begin
            if (sck_rise && mosi) begin
              state_q <= GET_SGL;
            end
          end
          GET_SGL: begin
            if (sck_rise) begin
              sgl_q   <= mosi;
              state_q <= GET_ODD;
            end
          end
          GET_ODD: begin
            if (sck_rise) begin
              odd_q   <= mosi;
              state_q <= GET_MSBF;
            end
          end
          GET_MSBF: begin
            if (sck_rise) begin
              o_CFG    <= {sgl_q, odd_q, mosi};
              sample_q <= use_ch1({sgl_q, odd_q, mosi}) ? i_CH1_DATA : i_CH0_DATA;
              state_q  <= NULL_BIT;
            end
          end
          NULL_BIT: begin
            if (sck_fall) begin
              o_MISO  <= NULL_BIT_VAL;
              idx_q   <= IDX_LAST;
              state_q <= SHIFT_MSB;
            end
          end
          SHIFT_MSB: begin
            if (sck_fall) begin
              o_MISO <= sample_q[idx_q];
              if (idx_q == '0) begin
                if (o_CFG[CFG_MSBF]) begin
                  state_q     <= HOLD;
                  o_CONV_DONE <= 1'b1;
                end else begin
                  idx_q   <= IDX_W'(1);
                  state_q <= SHIFT_LSB;
                end
              end else begin
                idx_q <= idx_q - IDX_W'(1);
              end
            end
          end
          SHIFT_LSB: begin
            if (sck_fall) begin
              o_MISO <= sample_q[idx_q];
              if (idx_q == IDX_LAST) begin
                state_q     <= HOLD;
                o_CONV_DONE <= 1'b1;
              end else begin
                idx_q <= idx_q + IDX_W'(1);
              end
            end
          end
          HOLD: begin
            // The last data bit stays valid until the master's next fall.
            if (sck_fall) begin
              o_MISO <= 1'b0;
            end
          end
          default: begin
            state_q   <= IDLE;
            o_MISO    <= 1'b0;
            o_MISO_OE <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_mcp3202_responder.sv
// Directed bench for spi_mcp3202_responder: acts as the SPI master and checks
// MISO framing, channel select, bit order, abort and reset behaviour.
module tb_spi_mcp3202_responder;

  localparam int DW = 12;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cs;
  logic          sck;
  logic          mosi;
  logic [DW-1:0] ch0;
  logic [DW-1:0] ch1;
  logic          miso;
  logic          miso_oe;
  logic [2:0]    cfg;
  logic          conv_done;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  logic [63:0] rx;
  logic        oe_all;
  logic        oe_any;
  int          d0;

  spi_mcp3202_responder #(
    .DATA_WIDTH  (DW),
    .SYNC_STAGES (SS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_CS        (cs),
    .i_SCK       (sck),
    .i_MOSI      (mosi),
    .i_CH0_DATA  (ch0),
    .i_CH1_DATA  (ch1),
    .o_MISO      (miso),
    .o_MISO_OE   (miso_oe),
    .o_CFG       (cfg),
    .o_CONV_DONE (conv_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (conv_done) done_cnt <= done_cnt + 1;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] cmd(input int z, input logic sgl, input logic odd, input logic msbf);
    logic [63:0] v;
    v = '0;
    v[z]   = 1'b1;
    v[z+1] = sgl;
    v[z+2] = odd;
    v[z+3] = msbf;
    return v;
  endfunction

  function automatic logic [11:0] msb_word(input logic [63:0] r, input int first);
    logic [11:0] w;
    for (int k = 0; k < 12; k++) w[11-k] = r[first+k];
    return w;
  endfunction

  // Bits as they arrive after B0 in LSB-first mode: w[0]=B1 ... w[10]=B11.
  function automatic logic [10:0] lsb_word(input logic [63:0] r, input int first);
    logic [10:0] w;
    for (int k = 0; k < 11; k++) w[k] = r[first+k];
    return w;
  endfunction

  // One SPI frame: MOSI set while SCK low, MISO sampled just before each rise.
  task automatic apply_stimulus(input int n, input logic [63:0] tx, input int chg_at,
                                output logic [63:0] r, output logic all_oe, output logic any_oe);
    r = '0;
    all_oe = 1'b1;
    any_oe = 1'b0;
    @(negedge clk);
    cs = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if (i == chg_at) begin
        ch0 = ~ch0;
        ch1 = ~ch1;
      end
      mosi = tx[i];
      repeat (8) @(negedge clk);
      r[i] = miso;
      all_oe = all_oe & miso_oe;
      any_oe = any_oe | miso_oe;
      sck = 1'b1;
      repeat (8) @(negedge clk);
      sck = 1'b0;
    end
    mosi = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_release(input string tag);
    @(negedge clk);
    cs = 1'b1;
    repeat (SS + 2) @(posedge clk);
    #1;
    check_output({tag, "_oe_off"}, 32'(miso_oe), 32'd0);
    check_output({tag, "_miso_off"}, 32'(miso), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst  = 1'b1;
    cs   = 1'b1;
    sck  = 1'b0;
    mosi = 1'b0;
    ch0  = '0;
    ch1  = '0;
    repeat (4) @(posedge clk);
    #1;
    check_output("rst_oe", 32'(miso_oe), 32'd0);
    check_output("rst_miso", 32'(miso), 32'd0);
    check_output("rst_cfg", 32'(cfg), 32'd0);
    check_output("rst_done", 32'(conv_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] ch0 single-ended MSB-first");
    ch0 = 12'hD73;
    ch1 = 12'hFFF;
    d0 = done_cnt;
    apply_stimulus(20, cmd(0, 1'b1, 1'b0, 1'b1), -1, rx, oe_all, oe_any);
    check_output("t1_cmd_phase", 32'(rx[3:0]), 32'd0);
    check_output("t1_null", 32'(rx[4]), 32'd0);
    check_output("t1_word", 32'(msb_word(rx, 5)), 32'hD73);
    check_output("t1_hold", 32'(rx[18:17]), 32'd0);
    check_output("t1_oe", 32'(oe_all), 32'd1);
    check_output("t1_cfg", 32'(cfg), 32'h5);
    check_output("t1_done", 32'(done_cnt - d0), 32'd1);
    cs_release("t1");

    $display("[TB] ch1 with inputs changing mid-frame");
    ch0 = 12'hABC;
    ch1 = 12'h003;
    d0 = done_cnt;
    apply_stimulus(20, cmd(0, 1'b1, 1'b1, 1'b1), 8, rx, oe_all, oe_any);
    check_output("t2_null", 32'(rx[4]), 32'd0);
    check_output("t2_word", 32'(msb_word(rx, 5)), 32'h003);
    check_output("t2_cfg", 32'(cfg), 32'h7);
    check_output("t2_done", 32'(done_cnt - d0), 32'd1);
    cs_release("t2");

    $display("[TB] three leading zeros");
    ch0 = 12'hA5C;
    ch1 = 12'h000;
    d0 = done_cnt;
    apply_stimulus(23, cmd(3, 1'b1, 1'b0, 1'b1), -1, rx, oe_all, oe_any);
    check_output("t3_cmd_phase", 32'(rx[6:0]), 32'd0);
    check_output("t3_null", 32'(rx[7]), 32'd0);
    check_output("t3_word", 32'(msb_word(rx, 8)), 32'hA5C);
    check_output("t3_cfg", 32'(cfg), 32'h5);
    check_output("t3_done", 32'(done_cnt - d0), 32'd1);
    cs_release("t3");

    $display("[TB] LSB-first tail");
    ch0 = 12'h801;
    d0 = done_cnt;
    apply_stimulus(32, cmd(0, 1'b1, 1'b0, 1'b0), -1, rx, oe_all, oe_any);
    check_output("t4_null", 32'(rx[4]), 32'd0);
    check_output("t4_msb_word", 32'(msb_word(rx, 5)), 32'h801);
    check_output("t4_lsb_word", 32'(lsb_word(rx, 17)), 32'h400);
    check_output("t4_hold", 32'(rx[29:28]), 32'd0);
    check_output("t4_cfg", 32'(cfg), 32'h4);
    check_output("t4_done", 32'(done_cnt - d0), 32'd1);
    cs_release("t4");

    $display("[TB] abort after five data bits");
    ch0 = 12'h000;
    ch1 = 12'h6E9;
    d0 = done_cnt;
    apply_stimulus(10, cmd(0, 1'b0, 1'b1, 1'b1), -1, rx, oe_all, oe_any);
    check_output("t5_bits", 32'({rx[5], rx[6], rx[7], rx[8], rx[9]}), 32'h0D);
    cs_release("t5");
    check_output("t5_no_done", 32'(done_cnt - d0), 32'd0);
    check_output("t5_cfg", 32'(cfg), 32'h3);
    ch0 = 12'h5A3;
    d0 = done_cnt;
    apply_stimulus(20, cmd(0, 1'b1, 1'b0, 1'b1), -1, rx, oe_all, oe_any);
    check_output("t5_next_word", 32'(msb_word(rx, 5)), 32'h5A3);
    check_output("t5_next_done", 32'(done_cnt - d0), 32'd1);
    cs_release("t5_next");

    $display("[TB] reset mid-shift with CS low");
    ch0 = 12'h3C6;
    apply_stimulus(8, cmd(0, 1'b0, 1'b0, 1'b1), -1, rx, oe_all, oe_any);
    check_output("t6_pre_cfg", 32'(cfg), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_output("t6_rst_oe", 32'(miso_oe), 32'd0);
    check_output("t6_rst_miso", 32'(miso), 32'd0);
    check_output("t6_rst_cfg", 32'(cfg), 32'd0);
    check_output("t6_rst_done", 32'(conv_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt;
    apply_stimulus(20, cmd(0, 1'b1, 1'b0, 1'b1), -1, rx, oe_all, oe_any);
    check_output("t6_silent_oe", 32'(oe_any), 32'd0);
    check_output("t6_silent_done", 32'(done_cnt - d0), 32'd0);
    check_output("t6_silent_cfg", 32'(cfg), 32'd0);
    cs_release("t6_silent");
    d0 = done_cnt;
    apply_stimulus(20, cmd(0, 1'b0, 1'b0, 1'b1), -1, rx, oe_all, oe_any);
    check_output("t6_word", 32'(msb_word(rx, 5)), 32'h3C6);
    check_output("t6_cfg", 32'(cfg), 32'h1);
    check_output("t6_done", 32'(done_cnt - d0), 32'd1);
    cs_release("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
